alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issue stage directly upstream of the 16-bit logic unit. Holds an 8-entry register file and accepts one instruction per handshake. Drives that instruction's operands onto bus1/bus2 and pulses exactly one one-hot op strobe, then asserts push (or pass) and writes the returned bus3 value back to the destination register. Consumers see done pulse on completion; registers readable via a debug port.

Parameters:
REG_COUNT, 8, number of 16-bit registers
ADDR_W, 3, register index width (log2 REG_COUNT)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  high only in IDLE; transfer when valid&&ready at rising edge
instr_op  input  4  0 add,1 sub,2 inc,3 dec,4 mul,5 shr,6 shl,7 band,8 bor,9 bxor,10 bnegate,11 mov,12 ldi,13-15 illegal
instr_rd  input  ADDR_W  destination register
instr_ra  input  ADDR_W  source A -> bus1
instr_rb  input  ADDR_W  source B -> bus2
instr_imm  input  16  immediate for ldi
bus1  output  16  operand A to logic unit
bus2  output  16  operand B to logic unit
bus3  input  16  result from logic unit (pass or push path)
pass, push, add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate  output  1 each  logic-unit strobes, at most one high per cycle
done  output  1  one-cycle pulse: writeback committed this edge
err  output  1  one-cycle pulse: illegal opcode discarded
dbg_sel  input  ADDR_W  debug read index
dbg_data  output  16  combinational R[dbg_sel]

Behaviour:
- Reset (async, any state): state=IDLE, all registers 0, latched instr fields 0, all strobes 0, bus1/bus2 0, done=0, err=0. Reset mid-operation abandons instruction; no writeback.
- States: IDLE, EXEC, PUSH, LDI.
- IDLE: instr_ready=1, strobes 0, bus1/bus2 0. On accept, latch op/rd/ra/rb/imm. Next state: op 0-11 -> EXEC; 12 -> LDI; 13-15 -> IDLE with err=1 next cycle, no register change.
- EXEC (1 cycle): bus1=R[ra], bus2=R[rb] (read at EXEC time, so reflects any write committed on the entry edge). Op 0-10: assert matching strobe only -> PUSH; logic unit latches result at end of EXEC. Op 11 (mov): assert pass only; at end of cycle R[rd]<=bus3, done=1 next cycle -> IDLE.
- PUSH (1 cycle): push=1, other strobes 0, bus1/bus2 held. At end of cycle R[rd]<=bus3, done pulses, -> IDLE.
- LDI (1 cycle): R[rd]<=imm, done pulses, -> IDLE.
- Latency, accept edge = T0: ALU ops write at T2 edge (done high T2-T3); mov and ldi write at T1 edge. Throughput: one ALU op per 3 cycles, mov/ldi per 2.
- Widths: results truncated to 16 bits (mul returns low half via push). shr/shl shift amount is full 16-bit R[rb]; amount >=16 yields 0.
- rd may equal ra/rb; operands sampled before writeback. dbg_data reads pre-write value during the writeback cycle.
- instr_valid while not ready: ignored, not queued; fields may change freely.
- Strobe one-hotness is a hard invariant: never two of {pass,push,ops} high in one cycle.

Test Plan:
- Reset then ldi R1=0x0005, ldi R2=0x0003, add R3=R1+R2 -> done 3 cycles after add accepted, dbg R3=0x0008; add high exactly 1 cycle, push the following cycle.
- sub R4=R2-R1 (3-5) -> R4=0xFFFE; mul R5=0x0100*0x0100 -> R5=0x0000 (low half).
- shl R6=R1<<R2 -> 0x0028; shl with R2=0x0010 -> 0x0000; bnegate R7 of R2=0x0003 -> 0xFFFC; mov R0=R1 -> done 2 cycles after accept, R0=0x0005.
- op 14 accepted -> err one cycle, no done, all registers unchanged, ready returns next cycle.
- Assert rst during PUSH of add -> all strobes 0 immediately, registers 0, ready=1 after release, no done.
- Back-to-back valid held high: ready only in IDLE, ldi R3=0xABCD then add R3=R3+R3 -> R3=0x579A; assertion checks one-hot strobes every cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issue stage for the 16-bit logic unit: 8x16 register file, operand drive, one-hot op strobe, writeback.
// Latency: ALU op writes 2 edges after accept, mov/ldi 1 edge; instr_ready only in IDLE, offers elsewhere are dropped.
module alu_sequencer #(
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [15:0]       instr_imm,
  output logic [15:0]       bus1,
  output logic [15:0]       bus2,
  input  logic [15:0]       bus3,
  output logic              pass,
  output logic              push,
  output logic              add,
  output logic              sub,
  output logic              inc,
  output logic              dec,
  output logic              mul,
  output logic              shr,
  output logic              shl,
  output logic              band,
  output logic              bor,
  output logic              bxor,
  output logic              bnegate,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [15:0]       dbg_data
);

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_INC     = 4'd2;
  localparam logic [3:0] OP_DEC     = 4'd3;
  localparam logic [3:0] OP_MUL     = 4'd4;
  localparam logic [3:0] OP_SHR     = 4'd5;
  localparam logic [3:0] OP_SHL     = 4'd6;
  localparam logic [3:0] OP_BAND    = 4'd7;
  localparam logic [3:0] OP_BOR     = 4'd8;
  localparam logic [3:0] OP_BXOR    = 4'd9;
  localparam logic [3:0] OP_BNEGATE = 4'd10;
  localparam logic [3:0] OP_MOV     = 4'd11;
  localparam logic [3:0] OP_LDI     = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    PUSH = 2'd2,
    LDI  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       regs [REG_COUNT];
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] rb_q;
  logic [15:0]       imm_q;
  logic              accept;
  logic              wr_en;
  logic [15:0]       wr_dat;
  logic              done_nxt;
  logic              err_nxt;

  assign accept   = instr_valid && instr_ready;
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        ra_q  <= instr_ra;
        rb_q  <= instr_rb;
        imm_q <= instr_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_q] <= wr_dat;
    end
  end

  // Strobes and buses decode from state so an async reset clears them immediately.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    bus1        = '0;
    bus2        = '0;
    pass        = 1'b0;
    push        = 1'b0;
    add         = 1'b0;
    sub         = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    mul         = 1'b0;
    shr         = 1'b0;
    shl         = 1'b0;
    band        = 1'b0;
    bor         = 1'b0;
    bxor        = 1'b0;
    bnegate     = 1'b0;
    wr_en       = 1'b0;
    wr_dat      = bus3;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (instr_op <= OP_MOV)      state_nxt = EXEC;
          else if (instr_op == OP_LDI) state_nxt = LDI;
          else                         err_nxt   = 1'b1;
        end
      end

      EXEC: begin
        bus1 = regs[ra_q];
        bus2 = regs[rb_q];
        case (op_q)
          OP_ADD:     add     = 1'b1;
          OP_SUB:     sub     = 1'b1;
          OP_INC:     inc     = 1'b1;
          OP_DEC:     dec     = 1'b1;
          OP_MUL:     mul     = 1'b1;
          OP_SHR:     shr     = 1'b1;
          OP_SHL:     shl     = 1'b1;
          OP_BAND:    band    = 1'b1;
          OP_BOR:     bor     = 1'b1;
          OP_BXOR:    bxor    = 1'b1;
          OP_BNEGATE: bnegate = 1'b1;
          OP_MOV:     pass    = 1'b1;
          default:    ;
        endcase
        if (op_q == OP_MOV) begin
          wr_en     = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = PUSH;
        end
      end

      PUSH: begin
        // Register file is unchanged since EXEC, so re-reading holds the operands.
        bus1      = regs[ra_q];
        bus2      = regs[rb_q];
        push      = 1'b1;
        wr_en     = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      LDI: begin
        wr_en     = 1'b1;
        wr_dat    = imm_q;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: behavioural register-file model plus a simple logic-unit responder.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_ra;
  logic [2:0]  instr_rb;
  logic [15:0] instr_imm;
  logic [15:0] bus1;
  logic [15:0] bus2;
  logic [15:0] bus3;
  logic        pass, push, add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate;
  logic        done;
  logic        err;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [12:0] stb;
  logic [15:0] lu_q = '0;
  logic [15:0] ref_r [8];

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  alu_sequencer #(.REG_COUNT(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm(instr_imm),
    .bus1(bus1), .bus2(bus2), .bus3(bus3),
    .pass(pass), .push(push), .add(add), .sub(sub), .inc(inc), .dec(dec), .mul(mul),
    .shr(shr), .shl(shl), .band(band), .bor(bor), .bxor(bxor), .bnegate(bnegate),
    .done(done), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // bit 0 pass, bit 1 push, bit 2+op for ALU opcodes 0..10
  assign stb = {bnegate, bxor, bor, band, shl, shr, mul, dec, inc, sub, add, push, pass};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a + 16'd1;
      4'd3:  return a - 16'd1;
      4'd4:  return p[15:0];
      4'd5:  return (b >= 16'd16) ? 16'd0 : (a >> b);
      4'd6:  return (b >= 16'd16) ? 16'd0 : (a << b);
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd10: return ~a;
      4'd11: return a;
      default: return 16'd0;
    endcase
  endfunction

  // Logic unit: latches its result at the end of the strobe cycle, pass is combinational.
  always @(posedge clk) begin
    for (int k = 0; k < 11; k++)
      if (stb[k+2]) lu_q <= ref_alu(4'(k), bus1, bus2);
  end
  assign bus3 = pass ? bus1 : lu_q;

  always @(negedge clk) begin
    if (!rst) check_eq("onehot", 32'($countones(stb) <= 1), 1);
  end

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check_eq(tag, {13'd0, 3'(i), dbg_data}, {13'd0, 3'(i), ref_r[i]});
    end
  endtask

  task automatic dbg_expect(input string tag, input logic [2:0] idx, input logic [15:0] val);
    dbg_sel = idx;
    #1;
    check_eq(tag, dbg_data, val);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [15:0] imm);
    int          exp_lat;
    int          got;
    int          idx;
    logic [12:0] exp_stb;
    @(negedge clk);
    check_eq("idle_ready", instr_ready, 1);
    check_eq("idle_done", done, 0);
    check_eq("idle_err", err, 0);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_ra    = ra;
    instr_rb    = rb;
    instr_imm   = imm;
    exp_lat     = (op <= 4'd10) ? 3 : (op <= 4'd12) ? 2 : 1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op    = 4'($urandom);
    instr_rd    = 3'($urandom);
    instr_ra    = 3'($urandom);
    instr_rb    = 3'($urandom);
    instr_imm   = 16'($urandom);
    got = 0;
    for (int c = 1; c <= 5 && got == 0; c++) begin
      @(negedge clk);
      exp_stb = '0;
      if (op <= 4'd10) begin
        idx = int'(op) + 2;
        if (c == 1) exp_stb[idx] = 1'b1;
        else if (c == 2) exp_stb[1] = 1'b1;
      end else if (op == 4'd11 && c == 1) begin
        exp_stb[0] = 1'b1;
      end
      check_eq("strobes", 32'(exp_stb ^ stb), 0);
      if (exp_stb != 0) begin
        check_eq("bus1", bus1, ref_r[ra]);
        check_eq("bus2", bus2, ref_r[rb]);
      end
      if (op <= 4'd10 && c == 2) dbg_expect("dbg_prewrite", rd, ref_r[rd]);
      if (done || err) got = c;
      else check_eq("busy_ready", instr_ready, 0);
    end
    check_eq("latency", got, exp_lat);
    check_eq("done_flag", done, 32'(op <= 4'd12));
    check_eq("err_flag", err, 32'(op > 4'd12));
    if (op <= 4'd11) ref_r[rd] = ref_alu(op, ref_r[ra], ref_r[rb]);
    else if (op == 4'd12) ref_r[rd] = imm;
    check_regs("regfile");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [3:0]  rop;
    logic [15:0] rimm;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_ra    = '0;
    instr_rb    = '0;
    instr_imm   = '0;
    dbg_sel     = '0;
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_strobes", stb, 0);
    check_eq("rst_bus1", bus1, 0);
    check_eq("rst_bus2", bus2, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    check_regs("rst_regs");

    // Directed sequence
    run_instr(4'd12, 3'd1, 3'd0, 3'd0, 16'h0005);
    run_instr(4'd12, 3'd2, 3'd0, 3'd0, 16'h0003);
    run_instr(4'd0,  3'd3, 3'd1, 3'd2, 16'h0);
    dbg_expect("add_r3", 3'd3, 16'h0008);
    run_instr(4'd1,  3'd4, 3'd2, 3'd1, 16'h0);
    dbg_expect("sub_r4", 3'd4, 16'hFFFE);
    run_instr(4'd12, 3'd5, 3'd0, 3'd0, 16'h0100);
    run_instr(4'd4,  3'd5, 3'd5, 3'd5, 16'h0);
    dbg_expect("mul_r5", 3'd5, 16'h0000);
    run_instr(4'd6,  3'd6, 3'd1, 3'd2, 16'h0);
    dbg_expect("shl_r6", 3'd6, 16'h0028);
    run_instr(4'd12, 3'd2, 3'd0, 3'd0, 16'h0010);
    run_instr(4'd6,  3'd6, 3'd1, 3'd2, 16'h0);
    dbg_expect("shl16_r6", 3'd6, 16'h0000);
    run_instr(4'd12, 3'd2, 3'd0, 3'd0, 16'h0003);
    run_instr(4'd10, 3'd7, 3'd2, 3'd0, 16'h0);
    dbg_expect("bneg_r7", 3'd7, 16'hFFFC);
    run_instr(4'd11, 3'd0, 3'd1, 3'd0, 16'h0);
    dbg_expect("mov_r0", 3'd0, 16'h0005);
    run_instr(4'd14, 3'd3, 3'd1, 3'd2, 16'h1234);

    // Reset while the add is in PUSH
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 4'd0;
    instr_rd    = 3'd3;
    instr_ra    = 3'd1;
    instr_rb    = 3'd2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_push", push, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_strobes", stb, 0);
    check_eq("midrst_bus1", bus1, 0);
    check_eq("midrst_ready", instr_ready, 1);
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    check_regs("midrst_regs");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("postrst_done", done, 0);
      check_eq("postrst_ready", instr_ready, 1);
    end

    // Back-to-back with instr_valid held high
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 4'd12;
    instr_rd    = 3'd3;
    instr_imm   = 16'hABCD;
    @(posedge clk);
    #1;
    instr_op = 4'd0;
    instr_rd = 3'd3;
    instr_ra = 3'd3;
    instr_rb = 3'd3;
    @(negedge clk);
    check_eq("b2b_busy_ready", instr_ready, 0);
    @(negedge clk);
    check_eq("b2b_ldi_done", done, 1);
    check_eq("b2b_idle_ready", instr_ready, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_add_stb", stb, 13'h0004);
    check_eq("b2b_exec_ready", instr_ready, 0);
    @(negedge clk);
    check_eq("b2b_push_stb", stb, 13'h0002);
    @(negedge clk);
    check_eq("b2b_add_done", done, 1);
    ref_r[3] = 16'h579A;
    check_regs("b2b_regs");
    dbg_expect("b2b_r3", 3'd3, 16'h579A);

    // Randomized traffic
    for (int i = 0; i < 8; i++) run_instr(4'd12, 3'(i), 3'd0, 3'd0, 16'($urandom));
    for (int n = 0; n < 300; n++) begin
      rop  = 4'($urandom_range(0, 15));
      rimm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run_instr(rop, 3'($urandom), 3'($urandom), 3'($urandom), rimm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
